axi_device_adapter: RTL and testbench
=====================================

Name: axi_device_adapter

Overview:
- Bridges one AXI slave port from the crossbar (axi_socket_1n device side) to a simple req/gnt/rvalid memory-style device such as RAM, sim control or timer.
- Accepts one AXI transaction at a time, converts it to a single device request, and returns the device response as an AXI B or R beat.
- Has at most one transaction outstanding.

Parameters:
- None. Widths come from top_pkg: AXI_AW=32, AXI_DW=32, AXI_DSW=4, AXI_IW=4.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset (async, active-low)
- req_o  out  1  device request
- gnt_i  in  1  device grant
- we_o  out  1  1=write, 0=read
- be_o  out  AXI_DSW  byte enables
- addr_o  out  AXI_AW  byte address
- wdata_o  out  AXI_DW  write data
- valid_i  in  1  device response valid; asserted for both reads and writes
- rdata_i  in  AXI_DW  read data
- err_i  in  1  device error
- axi_i  in  axi_h2d_t  AXI request channels from host/xbar
- axi_o  out  axi_d2h_t  AXI response channels to host/xbar

Behaviour:
- Reset (rst_ni, asynchronous, active-low; clock clk_i): state IDLE; all outputs 0, including req_o, all ready signals, bvalid and rvalid; captured registers cleared.
- Reset mid-operation aborts the transaction; no response is ever issued for it.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Write accept: when axi_i.awvalid and axi_i.wvalid are both 1, drive awready=wready=1 combinationally in that cycle. Capture awid, awaddr, wdata, wstrb, and is_write=1. Go to REQ.
  - Read accept: otherwise, when arvalid=1, drive arready=1 in that cycle. Capture arid and araddr, set is_write=0. Go to REQ.
  - Write has priority over read when both are pending.
  - awvalid without wvalid, or the reverse: accept nothing.
- REQ:
  - req_o=1, we_o=is_write, addr_o=captured address.
  - Writes: be_o=wstrb, wdata_o=wdata.
  - Reads: be_o=4'hF, wdata_o=0.
  - Hold req_o and all request fields stable until gnt_i=1, then go to WAIT.
  - req_o=0 in every other state.
- WAIT: on valid_i=1, capture rdata_i and err_i, then go to RESP. valid_i is ignored in all other states.
- RESP, write transaction:
  - bvalid=1, bid=captured id.
  - bresp=2'b10 (SLVERR) if the captured err is set, else 2'b00.
  - Go to IDLE on bready.
- RESP, read transaction:
  - rvalid=1, rid=captured id, rdata=captured data.
  - rresp set the same way as bresp.
  - rlast=rvalid.
  - Go to IDLE on rready.
- All response fields stay stable until the handshake completes.
- No ready signal is asserted outside IDLE.
- Latency with gnt_i tied high and a 1-cycle device:
  - cycle 0: AW/W accepted
  - cycle 1: req_o
  - cycle 2: valid_i
  - cycle 3: bvalid or rvalid
- Back-to-back throughput: one transaction per 4 cycles minimum.
- Addresses pass through unchanged; the device performs its own decode.

Decomposition:
- axi_pkg holds axi_h2d_t and axi_d2h_t.
  - axi_h2d_t fields: awid, awaddr, awvalid, wdata, wstrb, wvalid, bready, arid, araddr, arvalid, rready.
  - axi_d2h_t fields: awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid.
- axi_pkg also holds the resp constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
- top_pkg holds the width constants.
- No sub-module; single FSM plus capture registers.

Test Plan:
- Write: awaddr=0x100010, awid=3, wdata=0xDEADBEEF, wstrb=0xF, gnt_i=1, valid_i one cycle after req.
  - Required: req_o=1, we_o=1, addr_o=0x100010, wdata_o=0xDEADBEEF, be_o=0xF.
  - Then bvalid, bid=3, bresp=0.
- Read: araddr=0x30004, arid=5, rdata_i=0x12345678 on valid_i.
  - Required: we_o=0, be_o=0xF, then rvalid=rlast=1, rid=5, rdata=0x12345678, rresp=0.
- Simultaneous AW+W and AR in IDLE -> write is serviced first; the read is accepted only after bready returns the FSM to IDLE.
- gnt_i held low 3 cycles; then err_i=1 with valid_i.
  - Required: req_o and request fields stable for all 3 cycles.
  - Then bresp=SLVERR.
- bready low 4 cycles -> bvalid and bid held; awready stays 0 even with a new AW+W pending.
- Assert rst_ni=0 while in WAIT -> all outputs 0 immediately; no response after reset release.

Source files
------------

// File: rtl/axi_pkg.sv
// AXI channel bundles between crossbar and device side, response codes and
// the device adapter state encoding.
package axi_pkg;

  import top_pkg::*;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_IW-1:0]  awid;
    logic [AXI_AW-1:0]  awaddr;
    logic               awvalid;
    logic [AXI_DW-1:0]  wdata;
    logic [AXI_DSW-1:0] wstrb;
    logic               wvalid;
    logic               bready;
    logic [AXI_IW-1:0]  arid;
    logic [AXI_AW-1:0]  araddr;
    logic               arvalid;
    logic               rready;
  } axi_h2d_t;

  typedef struct packed {
    logic               awready;
    logic               wready;
    logic [AXI_IW-1:0]  bid;
    logic [1:0]         bresp;
    logic               bvalid;
    logic               arready;
    logic [AXI_IW-1:0]  rid;
    logic [AXI_DW-1:0]  rdata;
    logic [1:0]         rresp;
    logic               rlast;
    logic               rvalid;
  } axi_d2h_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } adapter_state_e;

  function automatic logic [1:0] resp_from_err(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/top_pkg.sv
// Bus width constants shared by the AXI crossbar and its device-side adapters.
package top_pkg;

  localparam int AXI_AW  = 32;
  localparam int AXI_DW  = 32;
  localparam int AXI_DSW = 4;
  localparam int AXI_IW  = 4;

endpackage

// File: rtl/axi_device_adapter.sv
// Single-outstanding bridge from one AXI slave port to a req/gnt/rvalid device:
// one AXI transaction becomes one device request and one B or R beat.
module axi_device_adapter
  import top_pkg::*;
  import axi_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               req_o,
  input  logic               gnt_i,
  output logic               we_o,
  output logic [AXI_DSW-1:0] be_o,
  output logic [AXI_AW-1:0]  addr_o,
  output logic [AXI_DW-1:0]  wdata_o,
  input  logic               valid_i,
  input  logic [AXI_DW-1:0]  rdata_i,
  input  logic               err_i,
  input  axi_h2d_t           axi_i,
  output axi_d2h_t           axi_o
);

  adapter_state_e     r_state;
  logic               r_req;
  logic               r_we;
  logic [AXI_DSW-1:0] r_be;
  logic [AXI_AW-1:0]  r_addr;
  logic [AXI_DW-1:0]  r_wdata;
  logic [AXI_IW-1:0]  r_id;
  logic               r_is_write;
  logic [AXI_DW-1:0]  r_rdata;
  logic               r_err;
  logic               r_bvalid;
  logic               r_rvalid;

  logic w_aw_accept;
  logic w_ar_accept;
  logic w_resp_done;

  // Readies are combinational in IDLE; gating with rst_ni keeps them low during reset.
  assign w_aw_accept = rst_ni && (r_state == ST_IDLE) && axi_i.awvalid && axi_i.wvalid;
  assign w_ar_accept = rst_ni && (r_state == ST_IDLE) && !(axi_i.awvalid && axi_i.wvalid)
                       && axi_i.arvalid;
  assign w_resp_done = (r_bvalid && axi_i.bready) || (r_rvalid && axi_i.rready);

  // Transaction FSM with registered device request and response fields.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_id       <= '0;
      r_is_write <= 1'b0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_bvalid   <= 1'b0;
      r_rvalid   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_aw_accept) begin
            r_state    <= ST_REQ;
            r_req      <= 1'b1;
            r_we       <= 1'b1;
            r_be       <= axi_i.wstrb;
            r_addr     <= axi_i.awaddr;
            r_wdata    <= axi_i.wdata;
            r_id       <= axi_i.awid;
            r_is_write <= 1'b1;
          end else if (w_ar_accept) begin
            r_state    <= ST_REQ;
            r_req      <= 1'b1;
            r_we       <= 1'b0;
            r_be       <= 4'hF;
            r_addr     <= axi_i.araddr;
            r_wdata    <= '0;
            r_id       <= axi_i.arid;
            r_is_write <= 1'b0;
          end
        end
        ST_REQ: begin
          if (gnt_i) begin
            r_state <= ST_WAIT;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
          end
        end
        ST_WAIT: begin
          if (valid_i) begin
            r_state  <= ST_RESP;
            r_rdata  <= rdata_i;
            r_err    <= err_i;
            r_bvalid <= r_is_write;
            r_rvalid <= !r_is_write;
          end
        end
        ST_RESP: begin
          if (w_resp_done) begin
            r_state    <= ST_IDLE;
            r_bvalid   <= 1'b0;
            r_rvalid   <= 1'b0;
            r_id       <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_is_write <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_req    <= 1'b0;
          r_bvalid <= 1'b0;
          r_rvalid <= 1'b0;
        end
      endcase
    end
  end

  assign req_o   = r_req;
  assign we_o    = r_we;
  assign be_o    = r_be;
  assign addr_o  = r_addr;
  assign wdata_o = r_wdata;

  // Assemble the AXI response bundle from the capture registers.
  always_comb begin
    axi_o         = '0;
    axi_o.awready = w_aw_accept;
    axi_o.wready  = w_aw_accept;
    axi_o.arready = w_ar_accept;
    axi_o.bid     = r_id;
    axi_o.bresp   = resp_from_err(r_err);
    axi_o.bvalid  = r_bvalid;
    axi_o.rid     = r_id;
    axi_o.rdata   = r_rdata;
    axi_o.rresp   = resp_from_err(r_err);
    axi_o.rlast   = r_rvalid;
    axi_o.rvalid  = r_rvalid;
  end

endmodule

// File: tb/tb_axi_device_adapter.sv
// Scoreboard bench for axi_device_adapter: expected B/R beats are queued when
// a transaction is offered and compared when the adapter responds.
module tb_axi_device_adapter;
  import top_pkg::*;
  import axi_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_o, gnt_i, we_o, valid_i, err_i;
  logic [3:0]  be_o;
  logic [31:0] addr_o, wdata_o, rdata_i;
  axi_h2d_t    h2d;
  axi_d2h_t    d2h;

  typedef struct packed {
    logic        wr;
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic [127:0] all_outs;

  assign all_outs = {req_o, we_o, be_o, addr_o, wdata_o, d2h};

  always #5 clk_i = ~clk_i;

  axi_device_adapter dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_o(req_o), .gnt_i(gnt_i), .we_o(we_o),
    .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o), .valid_i(valid_i),
    .rdata_i(rdata_i), .err_i(err_i), .axi_i(h2d), .axi_o(d2h)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one write (AW+W together) or one read and queue its expected beat.
  task automatic accept(input bit wr, input logic [3:0] id, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb,
                        input logic [31:0] rd, input logic err, input bit push);
    exp_t e;
    @(negedge clk_i);
    if (wr) begin
      h2d.awvalid = 1'b1; h2d.wvalid = 1'b1; h2d.awid = id;
      h2d.awaddr = addr; h2d.wdata = wd; h2d.wstrb = strb;
    end else begin
      h2d.arvalid = 1'b1; h2d.arid = id; h2d.araddr = addr;
    end
    #1;
    if (wr) check_eq("aw_w_ready", {d2h.awready, d2h.wready, d2h.arready}, 3'b110);
    else    check_eq("ar_ready", {d2h.awready, d2h.wready, d2h.arready}, 3'b001);
    if (push) begin
      e.wr = wr; e.id = id; e.data = wr ? 32'h0 : rd;
      e.resp = err ? 2'b10 : 2'b00;
      exp_q.push_back(e);
    end
    @(posedge clk_i); #1;
    h2d.awvalid = 1'b0; h2d.wvalid = 1'b0; h2d.arvalid = 1'b0;
  endtask

  // Device model: grant after gnt_low stalled cycles, answer one cycle later.
  task automatic device(input int gnt_low, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [31:0] rd, input logic err);
    for (int i = 0; i <= gnt_low; i++) begin
      @(negedge clk_i);
      check_eq("req_o", req_o, 1'b1);
      check_eq("req_fields", {we_o, be_o, addr_o, wdata_o}, {we, be, addr, wd});
      gnt_i = (i == gnt_low);
    end
    @(negedge clk_i);
    gnt_i = 1'b0;
    check_eq("req_drop", req_o, 1'b0);
    valid_i = 1'b1; rdata_i = rd; err_i = err;
    @(negedge clk_i);
    valid_i = 1'b0; err_i = 1'b0; rdata_i = 32'h0;
    check_eq("resp_latency", d2h.bvalid | d2h.rvalid, 1'b1);
  endtask

  // Wait (bounded) for a B/R beat, compare against the scoreboard, then handshake.
  task automatic collect(input int stall, input bit pend_wr);
    exp_t e;
    bit   got;
    int   n;
    got = 1'b0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk_i);
      got = d2h.bvalid | d2h.rvalid;
      n++;
    end
    if (!got) begin
      check_eq("resp_timeout", 1'b0, 1'b1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    if (exp_q.size() == 0) begin
      check_eq("unexpected_resp", 1'b1, 1'b0);
      return;
    end
    e = exp_q.pop_front();
    check_eq("no_ready_resp", {d2h.awready, d2h.wready, d2h.arready}, 3'b000);
    for (int s = 0; s <= stall; s++) begin
      if (e.wr) begin
        check_eq("b_valid", {d2h.bvalid, d2h.rvalid}, 2'b10);
        check_eq("b_id_resp", {d2h.bid, d2h.bresp}, {e.id, e.resp});
      end else begin
        check_eq("r_valid", {d2h.rvalid, d2h.rlast, d2h.bvalid}, 3'b110);
        check_eq("r_id_data_resp", {d2h.rid, d2h.rdata, d2h.rresp}, {e.id, e.data, e.resp});
      end
      if (s < stall) begin
        h2d.awvalid = pend_wr; h2d.wvalid = pend_wr;
        h2d.awid = 4'hE; h2d.awaddr = 32'h500; h2d.wdata = 32'h77; h2d.wstrb = 4'hF;
        #1;
        check_eq("awready_in_resp", {d2h.awready, d2h.wready}, 2'b00);
        @(negedge clk_i);
      end
    end
    h2d.awvalid = 1'b0; h2d.wvalid = 1'b0;
    if (e.wr) h2d.bready = 1'b1;
    else      h2d.rready = 1'b1;
    @(posedge clk_i); #1;
    h2d.bready = 1'b0; h2d.rready = 1'b0;
    check_eq("resp_drop", {d2h.bvalid, d2h.rvalid}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit   seen;
    exp_t e;
    rst_ni = 1'b0; gnt_i = 1'b0; valid_i = 1'b0; err_i = 1'b0; rdata_i = 32'h0;
    h2d = '0;
    repeat (2) @(negedge clk_i);
    check_eq("reset_outs", all_outs, 128'h0);
    rst_ni = 1'b1;

    // Plain write then plain read
    accept(1'b1, 4'd3, 32'h0010_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 1'b1);
    device(0, 1'b1, 32'h0010_0010, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
    collect(0, 1'b0);

    accept(1'b0, 4'd5, 32'h0003_0004, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 1'b1);
    device(0, 1'b0, 32'h0003_0004, 4'hF, 32'h0, 32'h1234_5678, 1'b0);
    collect(0, 1'b0);

    // Simultaneous AW+W and AR: write first, read only after B handshake
    @(negedge clk_i);
    h2d.awvalid = 1'b1; h2d.wvalid = 1'b1; h2d.awid = 4'd1; h2d.awaddr = 32'h40;
    h2d.wdata = 32'hA5A5_A5A5; h2d.wstrb = 4'hC;
    h2d.arvalid = 1'b1; h2d.arid = 4'd2; h2d.araddr = 32'h80;
    #1;
    check_eq("prio_ready", {d2h.awready, d2h.wready, d2h.arready}, 3'b110);
    e = '{wr: 1'b1, id: 4'd1, data: 32'h0, resp: 2'b00};
    exp_q.push_back(e);
    @(posedge clk_i); #1;
    h2d.awvalid = 1'b0; h2d.wvalid = 1'b0;
    device(0, 1'b1, 32'h40, 4'hC, 32'hA5A5_A5A5, 32'h0, 1'b0);
    collect(0, 1'b0);
    check_eq("ar_after_b", d2h.arready, 1'b1);
    e = '{wr: 1'b0, id: 4'd2, data: 32'h0BAD_F00D, resp: 2'b00};
    exp_q.push_back(e);
    @(posedge clk_i); #1;
    h2d.arvalid = 1'b0;
    device(0, 1'b0, 32'h80, 4'hF, 32'h0, 32'h0BAD_F00D, 1'b0);
    collect(0, 1'b0);

    // Grant held off 3 cycles, device error -> SLVERR
    accept(1'b1, 4'd7, 32'h2000, 32'h1122_3344, 4'h3, 32'h0, 1'b1, 1'b1);
    device(3, 1'b1, 32'h2000, 4'h3, 32'h1122_3344, 32'h0, 1'b1);
    collect(0, 1'b0);

    // Read error path
    accept(1'b0, 4'd6, 32'h3000, 32'h0, 4'h0, 32'hCAFE_0001, 1'b1, 1'b1);
    device(1, 1'b0, 32'h3000, 4'hF, 32'h0, 32'hCAFE_0001, 1'b1);
    collect(2, 1'b0);

    // bready low 4 cycles with a new AW+W waiting
    accept(1'b1, 4'd9, 32'h44, 32'h55, 4'hF, 32'h0, 1'b0, 1'b1);
    device(0, 1'b1, 32'h44, 4'hF, 32'h55, 32'h0, 1'b0);
    collect(4, 1'b1);

    // Reset while waiting for the device response
    accept(1'b1, 4'd4, 32'h88, 32'h66, 4'hF, 32'h0, 1'b0, 1'b0);
    @(negedge clk_i);
    check_eq("req_before_rst", req_o, 1'b1);
    gnt_i = 1'b1;
    @(negedge clk_i);
    gnt_i = 1'b0;
    rst_ni = 1'b0; valid_i = 1'b1;
    #1;
    check_eq("reset_wait_outs", all_outs, 128'h0);
    @(negedge clk_i);
    valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk_i);
      if (d2h.bvalid || d2h.rvalid || req_o) seen = 1'b1;
    end
    check_eq("no_resp_after_reset", seen, 1'b0);

    check_eq("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
